// File: rtl/mem_fill_pkg.sv
// rtl/mem_fill_pkg.sv - shared types and constants for the cache fill responder
// Contents: fill FSM state enum, default block geometry, arbiter select encoding.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int BLOCK_WORDS_DEFAULT = 8;
    localparam int OFFSET_BITS         = $clog2(BLOCK_WORDS_DEFAULT * 2);

    // Select encoding produced by the cache miss arbiter.
    localparam logic SEL_INSTR = 1'b1;
    localparam logic SEL_DATA  = 1'b0;

    // Number of byte-offset bits inside one block of 16-bit words.
    function automatic int offset_bits(input int block_words);
        return $clog2(block_words * 2);
    endfunction

endpackage

// File: rtl/mem_fill_responder_counter.sv
// rtl/mem_fill_responder_counter.sv - saturating word counter with terminal-count flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over inc)
//   inc        : count up by one; holds once MAX_COUNT is reached
//   count      : current value
//   tc         : high when count == MAX_COUNT
module fill_word_counter #(
    parameter int MAX_COUNT = 8,
    parameter int CNT_W     = $clog2(MAX_COUNT) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(MAX_COUNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_fill_responder.sv
// rtl/mem_fill_responder.sv - memory-side responder that streams one cache block per miss
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_addr/req_sel       : arbitrated miss (sel 1 = instr, 0 = data)
//   req_ready                        : high only while idle
//   mem_en/mem_addr                  : pipelined word read issue, one per cycle
//   mem_rdata/mem_rvalid             : in-order read returns
//   fill_we_i/fill_we_d              : per-cache write strobes
//   fill_addr/fill_data              : byte address and data of the word being filled
//   fill_done_i/fill_done_d          : one-cycle block-complete pulses
//   busy                             : high whenever not idle
module mem_fill_responder
    import mem_fill_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_sel,
    output logic              req_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done_i,
    output logic              fill_done_d,
    output logic              busy
);

    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam int OFS_W = offset_bits(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFS_W) - ADDR_W'(1));

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic              sel_q;

    logic [CNT_W-1:0]  issue_cnt, recv_cnt;
    logic              issue_tc, recv_tc;
    logic              accept, issuing, rx, last_rx;

    assign accept  = (state_q == IDLE) && req_valid;
    assign issuing = (state_q == FILL) && !issue_tc;
    // Returns outside FILL or past the block end are dropped here.
    assign rx      = (state_q == FILL) && mem_rvalid && !recv_tc;
    assign last_rx = rx && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

    fill_word_counter #(.MAX_COUNT(BLOCK_WORDS), .CNT_W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (issuing),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    fill_word_counter #(.MAX_COUNT(BLOCK_WORDS), .CNT_W(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (rx),
        .count (recv_cnt),
        .tc    (recv_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            sel_q   <= SEL_DATA;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q <= req_addr & BASE_MASK;
                sel_q  <= req_sel;
            end
        end
    end

    // Address/data outputs are forced to zero when their strobe is low so the
    // bus is quiet outside real transfers (including during reset).
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        busy        = 1'b1;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_addr   = '0;
        fill_data   = '0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (issuing) begin
                    mem_en   = 1'b1;
                    // Block-aligned base: the offset never carries out of the block.
                    mem_addr = base_q + ADDR_W'({issue_cnt, 1'b0});
                end
                if (rx) begin
                    fill_we_i = (sel_q == SEL_INSTR);
                    fill_we_d = (sel_q == SEL_DATA);
                    fill_addr = base_q + ADDR_W'({recv_cnt, 1'b0});
                    fill_data = mem_rdata;
                end
                if (last_rx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                fill_done_i = (sel_q == SEL_INSTR);
                fill_done_d = (sel_q == SEL_DATA);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb/tb_mem_fill_responder.sv - directed vector bench for mem_fill_responder
module tb_mem_fill_responder;

    localparam int BW  = 8;
    localparam int LAT = 4;

    typedef struct {
        logic [15:0] addr;
        logic        sel;
        logic [15:0] exp_base;
        logic [31:0] gaps;      // extra return delay per word, 4 bits each
        logic        noise;     // toggle request inputs and inject stray rvalid
        logic [15:0] dbase;     // word k returns dbase + k
        int          idle_after;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_sel;
    logic        req_ready;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        fill_we_i;
    logic        fill_we_d;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vec_t tbl[6];

    mem_fill_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .fill_we_i   (fill_we_i),
        .fill_we_d   (fill_we_d),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data),
        .fill_done_i (fill_done_i),
        .fill_done_d (fill_done_d),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_now();
        return {req_ready, busy, mem_en, fill_we_i, fill_we_d, fill_done_i, fill_done_d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic spurious, input string tag);
        for (int i = 0; i < n; i++) begin
            req_valid  = 1'b0;
            mem_rvalid = spurious;
            mem_rdata  = 16'hDEAD;
            #2;
            chk($sformatf("%s idle%0d ctl", tag, i), 32'(ctl_now()), 32'(7'b1000000));
            next_cycle();
        end
        mem_rvalid = 1'b0;
    endtask

    // Caller is at the drive point of the cycle in which the request is offered.
    task automatic run_fill(input vec_t v, input int idx);
        int         ret_t[BW];
        int         last;
        int         nxt;
        logic       exp_en;
        logic       exp_rx;
        logic       is_done;
        logic [6:0] e;

        for (int k = 0; k < BW; k++) begin
            ret_t[k] = k + 1 + LAT;
            if (k > 0 && ret_t[k-1] + 1 > ret_t[k]) ret_t[k] = ret_t[k-1] + 1;
            ret_t[k] = ret_t[k] + int'(v.gaps[4*k +: 4]);
        end
        last = ret_t[BW-1];
        nxt  = 0;

        for (int cyc = 0; cyc <= last + 1; cyc++) begin
            if (cyc == 0) begin
                req_valid = 1'b1;
                req_addr  = v.addr;
                req_sel   = v.sel;
            end else if (v.noise) begin
                req_valid = 1'b1;
                req_addr  = 16'($urandom);
                req_sel   = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            exp_rx     = (nxt < BW) && (ret_t[nxt] == cyc);
            is_done    = (cyc == last + 1);
            mem_rvalid = exp_rx || (v.noise && is_done);
            mem_rdata  = exp_rx ? v.dbase + 16'(nxt) : 16'hBEEF;
            exp_en     = (cyc >= 1) && (cyc <= BW);
            #2;
            e = {cyc == 0, cyc != 0, exp_en, exp_rx & v.sel, exp_rx & ~v.sel,
                 is_done & v.sel, is_done & ~v.sel};
            chk($sformatf("v%0d c%0d ctl", idx, cyc), 32'(ctl_now()), 32'(e));
            if (exp_en)
                chk($sformatf("v%0d c%0d mem_addr", idx, cyc), 32'(mem_addr),
                    32'(v.exp_base + 16'(2 * (cyc - 1))));
            if (exp_rx) begin
                chk($sformatf("v%0d w%0d fill_addr", idx, nxt), 32'(fill_addr),
                    32'(v.exp_base + 16'(2 * nxt)));
                chk($sformatf("v%0d w%0d fill_data", idx, nxt), 32'(fill_data),
                    32'(v.dbase + 16'(nxt)));
                nxt++;
            end
            next_cycle();
        end
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
        idle_cycles(v.idle_after, v.noise, $sformatf("v%0d post", idx));
    endtask

    initial begin
        vec_t v_after;

        tbl[0] = '{16'h1236, 1'b1, 16'h1230, 32'h0000_0000, 1'b0, 16'hA000, 2};
        tbl[1] = '{16'h4C0A, 1'b0, 16'h4C00, 32'h3021_0312, 1'b0, 16'hB000, 0};
        tbl[2] = '{16'hFFFF, 1'b1, 16'hFFF0, 32'h0000_0000, 1'b0, 16'hC000, 1};
        tbl[3] = '{16'h0000, 1'b0, 16'h0000, 32'h1111_1111, 1'b1, 16'hD000, 2};
        tbl[4] = '{16'h801E, 1'b1, 16'h8010, 32'h2000_0003, 1'b1, 16'hE000, 0};
        tbl[5] = '{16'h7FF1, 1'b0, 16'h7FF0, 32'h0000_0000, 1'b0, 16'h1234, 2};
        v_after = '{16'h2468, 1'b1, 16'h2460, 32'h0000_0100, 1'b0, 16'h6600, 1};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 16'h0;
        req_sel    = 1'b0;
        mem_rdata  = 16'h0;
        mem_rvalid = 1'b0;

        @(posedge clk);
        next_cycle();
        chk("reset ctl", 32'(ctl_now()), 32'(7'b1000000));
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        rst_n = 1'b1;
        idle_cycles(2, 1'b1, "boot");

        for (int i = 0; i < 6; i++) run_fill(tbl[i], i);

        // Reset in the middle of a data fill.
        req_valid = 1'b1;
        req_addr  = 16'h3456;
        req_sel   = 1'b0;
        #2;
        chk("rst seq accept ctl", 32'(ctl_now()), 32'(7'b1000000));
        next_cycle();
        req_valid = 1'b0;
        req_sel   = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            mem_rvalid = (cyc == 5);
            mem_rdata  = 16'h5500;
            #2;
            if (cyc == 5) begin
                chk("rst seq c5 ctl", 32'(ctl_now()), 32'(7'b0110100));
                chk("rst seq c5 fill_addr", 32'(fill_addr), 32'h3450);
            end else begin
                chk($sformatf("rst seq c%0d ctl", cyc), 32'(ctl_now()), 32'(7'b0110000));
            end
            next_cycle();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5501;
        #1;
        chk("rst seq c6 pre ctl", 32'(ctl_now()), 32'(7'b0110100));
        rst_n = 1'b0;
        #1;
        chk("rst seq async ctl", 32'(ctl_now()), 32'(7'b1000000));
        chk("rst seq async addr", 32'({mem_addr, fill_addr}), 32'h0);
        chk("rst seq async data", 32'(fill_data), 32'h0);
        next_cycle();
        chk("rst seq held ctl", 32'(ctl_now()), 32'(7'b1000000));
        rst_n = 1'b1;
        idle_cycles(4, 1'b1, "late rvalid");
        run_fill(v_after, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fill_responder.md
# mem_fill_responder

Memory-side responder for cache miss requests. Accepts one arbitrated miss (address plus instr/data select), issues `BLOCK_WORDS` consecutive word reads to the pipelined main memory, and streams each returned word back to the cache that missed. It signals block completion with a one-cycle done pulse. Sits between the cache miss arbiter and main memory; one fill in flight at a time.

## Interface
- `BLOCK_WORDS`, 8: 16-bit words per cache block; power of two.
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in 1: miss pending at arbiter output.
- `req_addr` in ADDR_W: miss byte address.
- `req_sel` in 1: 1 = instr cache, 0 = data cache.
- `req_ready` out 1: high only in IDLE; accept = `req_valid & req_ready`.
- `mem_en` out 1: memory read strobe, one word per cycle.
- `mem_addr` out ADDR_W: word-aligned read address.
- `mem_rdata` in DATA_W: returned word.
- `mem_rvalid` in 1: `mem_rdata` valid; returns in issue order.
- `fill_we_i` out 1: write strobe to the instr cache.
- `fill_we_d` out 1: write strobe to the data cache.
- `fill_addr` out ADDR_W: byte address of the word being filled.
- `fill_data` out DATA_W: the word being filled.
- `fill_done_i` out 1: one-cycle pulse, instr block complete.
- `fill_done_d` out 1: one-cycle pulse, data block complete.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, FILL, DONE.
- **IDLE**
  - `req_ready=1`.
  - On accept, latch `sel_q=req_sel` and `base_q=req_addr` with the low log2(BLOCK_WORDS*2) bits cleared.
  - Clear `issue_cnt` and `recv_cnt`, then go to FILL.
- **FILL**
  - **Issue side:** while `issue_cnt < BLOCK_WORDS`, drive `mem_en=1` and `mem_addr = base_q + 2*issue_cnt`, then increment `issue_cnt`.
  - **Receive side:** on each `mem_rvalid`, assert exactly one fill strobe (`fill_we_i` if `sel_q`, else `fill_we_d`).
    - `fill_addr = base_q + 2*recv_cnt`; `fill_data = mem_rdata`, passed through combinationally; increment `recv_cnt`.
  - Issue and receive overlap.
  - When the rvalid for word `BLOCK_WORDS-1` is consumed, go to DONE.
- **DONE:** pulse `fill_done_i` or `fill_done_d` per `sel_q` for one cycle, then go to IDLE.
- **Counter width:** log2(BLOCK_WORDS)+1 bits.
- **Address arithmetic:** ADDR_W bits. Base is block-aligned, so no carry leaves the block; block 0xFFF0 fills 0xFFF0..0xFFFE.
- **Boundary conditions:**
  - `mem_rvalid` in IDLE or DONE, or beyond `BLOCK_WORDS` received: ignored, no strobe.
  - `req_sel`/`req_addr` changes after accept: ignored until the next accept.
  - `req_valid` still high in the IDLE cycle after DONE: accepted as a new fill. The cache must clear its miss by the cycle after `fill_done_*`.
  - `mem_rvalid` arriving in the same cycle as the last issue: both handled.
- **Reset, asserted any time:** state goes to IDLE and counters to 0. The in-flight memory returns that follow are ignored.
  - All outputs 0 except `req_ready=1`.

## Timing
- Accept at cycle 0; `mem_en` high cycles 1..BLOCK_WORDS.
- Memory latency L (4 in this system): words return cycles 1+L..BLOCK_WORDS+L, with the fill strobe in the same cycle as each.
- `fill_done_*` in cycle BLOCK_WORDS+L+1; `req_ready` high in cycle BLOCK_WORDS+L+2.
- Default configuration: 8 issues, done at cycle 13, ready at cycle 14.
- No output is asserted in the accept cycle.
- Strobe outputs are combinational from state and `mem_rvalid`. State, counters, `base_q` and `sel_q` are registered.

## Structure
- **Shared package `mem_fill_pkg`:**
  - state enum (`IDLE`, `FILL`, `DONE`);
  - `BLOCK_WORDS` default;
  - `OFFSET_BITS` = log2(BLOCK_WORDS*2);
  - `SEL_INSTR=1'b1`, `SEL_DATA=1'b0`, matching the arbiter's select encoding.
- **Sub-module `fill_word_counter`:** parameterized saturating up-counter with a terminal-count flag. Instantiated twice, for issue and receive.

## Test plan
- **Instr fill:** `req_addr=0x1236`, `req_sel=1`, memory L=4 returns `0xA000+i` -> `mem_addr` 0x1230..0x123E in cycles 1-8; `fill_we_i` cycles 5-12 with `fill_addr` 0x1230+2i and data `0xA000+i`; `fill_done_i` at cycle 13; `fill_we_d` never high.
- **Data fill with stalled returns:** `req_sel=0`, `mem_rvalid` gaps of 0-3 cycles -> exactly 8 `fill_we_d` pulses in order; `fill_done_d` one cycle after the 8th.
- **Wrap edge:** `req_addr=0xFFFF` -> addresses 0xFFF0..0xFFFE; no address exceeds 0xFFFE.
- **Input noise:** `req_valid` held high with `req_sel` and `req_addr` toggling during FILL; spurious `mem_rvalid` in IDLE -> no re-accept, no extra strobes; original block filled.
- **Reset mid-fill:** `rst_n` low at cycle 6 -> outputs 0 and `req_ready=1` asynchronously; late `mem_rvalid` pulses produce no strobes; a new request then completes normally.
